alu_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer that shares a single 4-bit ALU.
- Accepts operation requests over valid/ready handshakes and registers the operands.
- Drives the shared ALU's A/B/Sel inputs, captures Result/CarryOut/Zero, and returns a tagged response over a valid/ready handshake.
- Sits between the datapath clients and the combinational ALU.

---
 rtl/alu_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one combinational ALU between two requesters. Requests arrive over
//   valid/ready handshakes. Each accepted operation takes one cycle to execute
//   on the ALU. The result is returned as a response tagged with the
//   requester ID.
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     reqN_valid / reqN_ready     request handshake, N = 0,1 (ready is combinational)
//     reqN_a, reqN_b, reqN_sel    request operands and opcode
//     alu_a, alu_b, alu_sel       drive to the shared ALU (latched operands)
//     alu_result/carry/zero       returned from the shared ALU
//     rsp_valid / rsp_ready       response handshake
//     rsp_id, rsp_result,
//     rsp_carry, rsp_zero         captured response fields
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; grants one and latches its fields
//   EXEC  | ALU sees the latched operands; results captured at cycle end
//   RESP  | response presented and held until rsp_ready
module alu_rr_arbiter #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic              grant0, grant1;

    // Grant only in IDLE. Under contention the requester not served last wins.
    // The rst_n term keeps both readies low while reset is held, even if a
    // requester is already asserting valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) grant0 = 1'b1;
                else              grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            IDLE: begin
                if (grant0) begin
                    a_d          = req0_a;
                    b_d          = req0_b;
                    sel_d        = req0_sel;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (grant1) begin
                    a_d          = req1_a;
                    b_d          = req1_b;
                    sel_d        = req1_sel;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d     = id_q;
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter. A small behavioural ALU closes the loop:
//   000 add (carry out), 001 sub (carry = borrow), 010 and, 011 or,
//   100 xor, 101 shl (carry = msb), 110 not a, 111 a-1 (carry = borrow).
module tb_alu_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_sel;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_sel;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry, alu_zero;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_result;
    logic       rsp_carry, rsp_zero;

    int checks = 0;
    int errors = 0;

    alu_rr_arbiter #(.DATA_W(4), .SEL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] alu_tmp;
    always_comb begin
        alu_tmp = 5'd0;
        case (alu_sel)
            3'd0: alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: alu_tmp = {1'b0, alu_a & alu_b};
            3'd3: alu_tmp = {1'b0, alu_a | alu_b};
            3'd4: alu_tmp = {1'b0, alu_a ^ alu_b};
            3'd5: alu_tmp = {alu_a, 1'b0};
            3'd6: alu_tmp = {1'b0, ~alu_a};
            default: alu_tmp = {1'b0, alu_a} - 5'd1;
        endcase
    end
    assign alu_result = alu_tmp[3:0];
    assign alu_carry  = alu_tmp[4];
    assign alu_zero   = (alu_tmp[3:0] == 4'd0);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the negedge at which the caller raised the valid(s)
    // in IDLE. Follows one operation through IDLE -> EXEC -> RESP with
    // rsp_ready high and returns at the negedge of the following IDLE cycle.
    task automatic run_op(input logic g, input logic drop0, input logic drop1,
                          input logic [3:0] e_res, input logic e_c, input logic e_z);
        #1;
        chk("grant_ready0", {7'd0, req0_ready}, {7'd0, ~g});
        chk("grant_ready1", {7'd0, req1_ready}, {7'd0, g});
        @(negedge clk);
        if (drop0) req0_valid = 1'b0;
        if (drop1) req1_valid = 1'b0;
        #1;
        chk("exec_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        chk("exec_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        @(negedge clk);
        #1;
        chk("rsp_valid", {7'd0, rsp_valid}, 8'd1);
        chk("rsp_id", {7'd0, rsp_id}, {7'd0, g});
        chk("rsp_result", {4'd0, rsp_result}, {4'd0, e_res});
        chk("rsp_carry", {7'd0, rsp_carry}, {7'd0, e_c});
        chk("rsp_zero", {7'd0, rsp_zero}, {7'd0, e_z});
        chk("resp_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_sel = 3'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_sel = 3'd0;
        rsp_ready  = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        chk("rst_rsp_fields", {1'b0, rsp_id, rsp_carry, rsp_zero, rsp_result}, 8'd0);
        chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requests: add with carry out, sub to zero
        req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd8; req0_sel = 3'b000;
        run_op(1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0);
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd5; req1_sel = 3'b001;
        run_op(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);

        // Contention: both valid for six ops, expected alternation 0,1,0,1,0,1
        req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_sel = 3'b010;
        req1_valid = 1'b1; req1_a = 4'b0011; req1_b = 4'b0100; req1_sel = 3'b011;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                run_op(1'b0, (k == 4), 1'b0, 4'b1000, 1'b0, 1'b0);
            else
                run_op(1'b1, 1'b0, (k == 5), 4'b0111, 1'b0, 1'b0);
        end
        chk("after_contention_idle", {7'd0, rsp_valid}, 8'd0);

        // Backpressure: response held for 5 cycles; request fields change
        // after acceptance and must not disturb the held response.
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'b000;
        #1;
        chk("bp_grant", {7'd0, req0_ready}, 8'd1);
        @(negedge clk);
        req0_a = 4'd4; req0_b = 4'd1; req0_sel = 3'b100;
        rsp_ready = 1'b0;
        #1;
        chk("bp_exec_ready", {7'd0, req0_ready}, 8'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_valid", {7'd0, rsp_valid}, 8'd1);
            chk("bp_hold_result", {3'd0, rsp_id, rsp_result}, 8'h03);
            chk("bp_hold_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {7'd0, req0_ready}, 8'd0);
        chk("bp_release_valid", {7'd0, rsp_valid}, 8'd1);
        @(negedge clk);
        run_op(1'b0, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);

        // Reset asserted during EXEC discards the in-flight operation
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_sel = 3'b000;
        #1;
        chk("rx_grant", {7'd0, req0_ready}, 8'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("rx_in_exec_alu_a", {4'd0, alu_a}, 8'd7);
        rst_n = 1'b0;
        #1;
        chk("rx_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rx_rsp_result", {4'd0, rsp_result}, 8'd0);
        chk("rx_alu_a", {4'd0, alu_a}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rx_no_rsp", {7'd0, rsp_valid}, 8'd0);
        end
        @(negedge clk);

        // After reset requester 0 wins contention; then not-a and decrement edges
        req0_valid = 1'b1; req0_a = 4'b0000; req0_b = 4'd0; req0_sel = 3'b111;
        req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'd0; req1_sel = 3'b110;
        run_op(1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
        #1;
        chk("final_idle", {5'd0, rsp_valid, req1_ready, req0_ready}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
